c1541_head_ctrl: RTL and testbench
==================================

C1541_HEAD_CTRL -- requirements
Module: c1541_head_ctrl

Interface
REQ-001 Parameter MAX_HTRACK, default 84, highest half-track position.
REQ-002 Parameter RESET_HTRACK, default 36, half-track position after reset.
REQ-003 Parameter SETTLE_CYCLES, default 4096, count of ce ticks the head must be quiet before `track` commits.
REQ-004 clk  in  1  drive clock; every register SHALL update on its rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 ce  in  1  drive clock-enable; stepper sampling and the settle counter SHALL advance only on ce=1.
REQ-007 stp  in  2  stepper phase from drive VIA.
REQ-008 mtr  in  1  spindle motor on.
REQ-009 act  in  1  drive activity LED.
REQ-010 we  in  1  GCR write strobe; 1 = current track buffer modified.
REQ-011 img_mounted  in  1  image change level; only its rising edge SHALL have effect.
REQ-012 track  out  7  committed half-track number, 0..MAX_HTRACK.
REQ-013 tr00_sense_n  out  1  0 when track==0, else 1.
REQ-014 save_track  out  1  toggle request; each edge = "write back buffer of current `track`".
REQ-015 settling  out  1  1 while a head move is not yet committed.

Function
REQ-016 On each ce tick: delta = (stp - stp_old) mod 4, then stp_old <= stp; stp_old SHALL track stp even when mtr=0.
REQ-017 A step is accepted only when mtr=1 and delta[0]=1; delta=01 SHALL be step-in, delta=11 SHALL be step-out; delta 00/10 SHALL produce no move.
REQ-018 Step-in SHALL increment internal position pos when pos<MAX_HTRACK; step-out SHALL decrement pos when pos>0; at a limit pos SHALL hold and the step still counts as accepted.
REQ-019 modified flag SHALL set on any clk with we=1.
REQ-020 On an accepted step with modified=1, save_track SHALL toggle in the same cycle and modified SHALL clear; if we=1 in that cycle, modified SHALL end at 1.
REQ-021 When modified=1 and act=0 (and no accepted step that cycle), save_track SHALL toggle and modified SHALL clear; at most one toggle per cycle.
REQ-022 Rising edge of img_mounted SHALL clear modified with no toggle; this SHALL take priority over we in the same cycle.
REQ-023 FSM states: IDLE, SETTLE. IDLE -> SETTLE on an accepted step; each further accepted step in SETTLE SHALL reload the counter to SETTLE_CYCLES-1.
REQ-024 In SETTLE, the counter SHALL decrement per ce tick; at 0 on a ce tick, track <= pos and state -> IDLE, in the same cycle.
REQ-025 settling SHALL be 1 exactly while state==SETTLE; track SHALL hold its old value throughout SETTLE, so any save_track toggle issued during a move refers to the pre-move track.
REQ-026 tr00_sense_n SHALL be registered-derived from track only (combinational OR of track bits).

Reset
REQ-027 reset SHALL set pos=track=RESET_HTRACK, modified=0, save_track=0, state=IDLE, counter=0, settling=0, tr00_sense_n=1 (for non-zero RESET_HTRACK).
REQ-028 reset SHALL load stp_old <= stp so that no step is taken on the first tick after reset.
REQ-029 reset mid-SETTLE SHALL abandon the move with no save toggle and no commit.

Configuration
REQ-030 Macro C1541_HEAD_SETTLE_EN: when defined, settle behaviour per REQ-023..025.
REQ-031 When not defined: no FSM or counter; track SHALL equal pos, updated in the cycle after the accepted step, and settling SHALL be tied 0. A save toggle on a step SHALL still be issued in the step cycle, before track changes.

Verification
REQ-032 Reset with stp=2, then 3 ce ticks stp=2 -> track=36, settling=0, save_track=0.
REQ-033 mtr=1, stp 0->1 on a ce tick -> pos=37, settling=1 until SETTLE_CYCLES ce ticks later, then track=37, settling=0.
REQ-034 we pulse, then step-out with act=1 -> save_track toggles in the step cycle while track=36; track=35 after settle.
REQ-035 pos=0, stp 1->0 (step-out) x3 -> track stays 0, tr00_sense_n=0; pos=84, step-in -> track stays 84.
REQ-036 we pulse while act=1, then act=0 -> one save_track toggle; img_mounted rise after a we pulse -> no toggle.
REQ-037 mtr=0, stp 0->1->2 -> no move; then mtr=1, stp 2->0 (delta 10) -> no move, stp_old=0.

Source files
------------

// File: rtl/c1541_head_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : c1541_head_ctrl
// Purpose  : 1541 drive head stepper decoder, half-track position and save
//            requests. Optional settle FSM enabled by C1541_HEAD_SETTLE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module c1541_head_ctrl #(
  parameter int MAX_HTRACK    = 84,
  parameter int RESET_HTRACK  = 36,
  parameter int SETTLE_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic [1:0] stp,
  input  logic       mtr,
  input  logic       act,
  input  logic       we,
  input  logic       img_mounted,
  output logic [6:0] track,
  output logic       tr00_sense_n,
  output logic       save_track,
  output logic       settling
);

  localparam logic [6:0] c_max_pos   = 7'(MAX_HTRACK);
  localparam logic [6:0] c_reset_pos = 7'(RESET_HTRACK);

  logic [1:0] r_stp_old;
  logic [6:0] r_pos;
  logic       r_img_prev;
  logic       r_modified;
  logic       r_save;

  logic [1:0] w_delta;
  logic       w_step;
  logic       w_step_in;
  logic       w_img_rise;

  // Phase delta of 01 is one step inward, 11 one step outward.
  always_comb begin
    w_delta    = stp - r_stp_old;
    w_step     = ce & mtr & w_delta[0];
    w_step_in  = (w_delta == 2'b01);
    w_img_rise = img_mounted & ~r_img_prev;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stp_old  <= stp;
      r_pos      <= c_reset_pos;
      r_img_prev <= img_mounted;
    end else begin
      r_img_prev <= img_mounted;
      if (ce)
        r_stp_old <= stp;
      if (w_step) begin
        if (w_step_in) begin
          if (r_pos < c_max_pos)
            r_pos <= r_pos + 7'd1;
        end else if (r_pos != 7'd0) begin
          r_pos <= r_pos - 7'd1;
        end
      end
    end
  end

  // A fresh image discards pending writes; otherwise flush on a step or when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_modified <= 1'b0;
      r_save     <= 1'b0;
    end else if (w_img_rise) begin
      r_modified <= 1'b0;
    end else if (r_modified && (w_step || !act)) begin
      r_save     <= ~r_save;
      r_modified <= we;
    end else if (we) begin
      r_modified <= 1'b1;
    end
  end

`ifdef C1541_HEAD_SETTLE_EN
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } state_t;

  localparam int c_cnt_w = $clog2(SETTLE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(SETTLE_CYCLES - 1);

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [6:0]         r_track;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_track <= c_reset_pos;
    end else if (w_step) begin
      r_state <= ST_SETTLE;
      r_cnt   <= c_reload;
    end else if (ce && (r_state == ST_SETTLE)) begin
      if (r_cnt == '0) begin
        r_track <= r_pos;
        r_state <= ST_IDLE;
      end else begin
        r_cnt <= r_cnt - c_cnt_w'(1);
      end
    end
  end

  assign track    = r_track;
  assign settling = (r_state == ST_SETTLE);
`else
  assign track    = r_pos;
  assign settling = 1'b0;
`endif

  assign save_track   = r_save;
  assign tr00_sense_n = |track;

endmodule
`default_nettype wire

// File: tb/tb_c1541_head_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_c1541_head_ctrl
// Purpose  : Scoreboard bench for c1541_head_ctrl against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_c1541_head_ctrl;

  localparam int MAX_HTRACK    = 84;
  localparam int RESET_HTRACK  = 36;
  localparam int SETTLE_CYCLES = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce = 1'b0;
  logic [1:0] stp = 2'd0;
  logic       mtr = 1'b0;
  logic       act = 1'b1;
  logic       we = 1'b0;
  logic       img_mounted = 1'b0;
  logic [6:0] track;
  logic       tr00_sense_n;
  logic       save_track;
  logic       settling;

  c1541_head_ctrl #(
    .MAX_HTRACK   (MAX_HTRACK),
    .RESET_HTRACK (RESET_HTRACK),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ce          (ce),
    .stp         (stp),
    .mtr         (mtr),
    .act         (act),
    .we          (we),
    .img_mounted (img_mounted),
    .track       (track),
    .tr00_sense_n(tr00_sense_n),
    .save_track  (save_track),
    .settling    (settling)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] trk;
    logic       stl;
    logic       sav;
    logic       t00n;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model: plain integers describing the drive's visible behaviour.
  int m_pos, m_track, m_stp_old, m_settle_left;
  bit m_dirty, m_save, m_img_old;
  bit settle_en;
  logic [1:0] cur_stp;

  initial begin
`ifdef C1541_HEAD_SETTLE_EN
    settle_en = 1'b1;
`else
    settle_en = 1'b0;
`endif
  end

  task automatic model_cycle();
    int  delta;
    bit  step, img_rise;
    exp_t e;
    if (reset) begin
      m_pos = RESET_HTRACK; m_track = RESET_HTRACK;
      m_dirty = 0; m_save = 0; m_settle_left = 0;
      m_stp_old = int'(stp); m_img_old = img_mounted;
    end else begin
      delta    = (int'(stp) - m_stp_old + 4) % 4;
      step     = ce && mtr && (delta % 2 == 1);
      img_rise = img_mounted && !m_img_old;
      if (img_rise) m_dirty = 0;
      else if (m_dirty && (step || !act)) begin m_save = !m_save; m_dirty = we; end
      else if (we) m_dirty = 1;
      if (step) begin
        if (delta == 1 && m_pos < MAX_HTRACK) m_pos++;
        else if (delta == 3 && m_pos > 0) m_pos--;
        if (settle_en) m_settle_left = SETTLE_CYCLES;
        else m_track = m_pos;
      end else if (settle_en && ce && m_settle_left > 0) begin
        m_settle_left--;
        if (m_settle_left == 0) m_track = m_pos;
      end
      if (ce) m_stp_old = int'(stp);
      m_img_old = img_mounted;
    end
    e.trk  = 7'(m_track);
    e.stl  = (m_settle_left > 0);
    e.sav  = m_save;
    e.t00n = (m_track != 0);
    exp_q.push_back(e);
  endtask

  task automatic tick(input logic r, input logic c, input logic [1:0] s,
                      input logic m, input logic a, input logic w, input logic i);
    @(negedge clk);
    reset = r; ce = c; stp = s; mtr = m; act = a; we = w; img_mounted = i;
    cur_stp = s;
    model_cycle();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(0, 1, cur_stp, 1, 1, 0, img_mounted);
  endtask

  task automatic step_dir(input bit inward, input int n);
    for (int k = 0; k < n; k++)
      tick(0, 1, inward ? cur_stp + 2'd1 : cur_stp - 2'd1, 1, 1, 0, img_mounted);
  endtask

  // Monitor: one expectation per clock edge, compared after outputs settle.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (track !== e.trk || settling !== e.stl || save_track !== e.sav ||
          tr00_sense_n !== e.t00n) begin
        errors++;
        $display("FAIL outputs @%0t: got track=%0d settling=%b save=%b tr00_n=%b, want track=%0d settling=%b save=%b tr00_n=%b",
                 $time, track, settling, save_track, tr00_sense_n,
                 e.trk, e.stl, e.sav, e.t00n);
      end
    end
  end

  initial begin
    cur_stp = 2'd2;
    // Reset with stp=2, then quiet ticks
    tick(1, 1, 2'd2, 0, 1, 0, 0);
    tick(1, 1, 2'd2, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) tick(0, 1, 2'd2, 1, 1, 0, 0);
    // Delta 10 produces no move; then single step in
    tick(0, 1, 2'd0, 1, 1, 0, 0);
    tick(0, 1, 2'd1, 1, 1, 0, 0);
    idle(SETTLE_CYCLES + 3);
    // Write pulse then step out with act held high
    tick(0, 0, 2'd1, 1, 1, 1, 0);
    tick(0, 1, 2'd0, 1, 1, 0, 0);
    idle(SETTLE_CYCLES + 3);
    // Drive to track 0 and beyond, then to the top limit and beyond
    step_dir(0, 40);
    idle(SETTLE_CYCLES + 3);
    step_dir(1, 90);
    idle(SETTLE_CYCLES + 3);
    // Idle flush once act drops
    tick(0, 0, cur_stp, 1, 1, 1, 0);
    tick(0, 0, cur_stp, 1, 1, 0, 0);
    tick(0, 0, cur_stp, 1, 0, 0, 0);
    tick(0, 0, cur_stp, 1, 0, 0, 0);
    // Image change discards a pending write
    tick(0, 0, cur_stp, 1, 1, 1, 0);
    tick(0, 0, cur_stp, 1, 1, 1, 1);
    tick(0, 0, cur_stp, 1, 0, 0, 1);
    tick(0, 0, cur_stp, 1, 0, 0, 0);
    // Motor off: stepper phases are tracked but ignored
    tick(0, 1, 2'd0, 0, 1, 0, 0);
    tick(0, 1, 2'd1, 0, 1, 0, 0);
    tick(0, 1, 2'd2, 0, 1, 0, 0);
    tick(0, 1, 2'd0, 1, 1, 0, 0);
    tick(0, 1, 2'd1, 1, 1, 0, 0);
    idle(SETTLE_CYCLES + 3);
    // Reset in the middle of a move
    step_dir(1, 1);
    tick(0, 1, cur_stp, 1, 1, 1, 0);
    tick(1, 1, cur_stp, 1, 1, 0, 0);
    idle(4);
    // Randomized traffic
    for (int k = 0; k < 4000; k++) begin
      logic [1:0] s;
      s = ($urandom_range(0, 3) == 0) ? 2'($urandom) : cur_stp;
      tick(($urandom_range(0, 599) == 0),
           ($urandom_range(0, 3) != 0),
           s,
           ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 39) == 0) ? ~img_mounted : img_mounted);
      if ($urandom_range(0, 99) == 0) idle(SETTLE_CYCLES + 2);
    end
    idle(2);
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
